// File: rtl/dbus_axil_bridge.sv
// VexRiscv simple data bus (dBus_cmd/dBus_rsp) responder re-issuing each access as one AXI4-Lite transaction.
// Optional watchdog: define DBUS_BRIDGE_TIMEOUT_EN to abort AXI accesses stalled for TIMEOUT_CYCLES.
module dbus_axil_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dBus_cmd_valid,
    output logic              dBus_cmd_ready,
    input  logic              dBus_cmd_payload_wr,
    input  logic [ADDR_W-1:0] dBus_cmd_payload_address,
    input  logic [31:0]       dBus_cmd_payload_data,
    input  logic [3:0]        dBus_cmd_payload_mask,
    input  logic [2:0]        dBus_cmd_payload_size,
    output logic              dBus_rsp_valid,
    output logic [31:0]       dBus_rsp_payload_data,
    output logic              dBus_rsp_payload_error,
    output logic              wr_error,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } state_t;

    state_t            state;
    logic              cmd_fire;
    logic              size_bad;
    logic              aw_done;
    logic              w_done;
    logic              tmo_hit;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_bits;

    assign dBus_cmd_ready = (state == IDLE) && !reset;
    assign cmd_fire       = dBus_cmd_valid && dBus_cmd_ready;
    assign size_bad       = (dBus_cmd_payload_size > 3'd2);
    assign word_addr      = {dBus_cmd_payload_address[ADDR_W-1:2], 2'b00};

    // A channel counts as done once its valid has dropped or is being accepted this cycle.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid || m_axi_wready;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign unused_bits = &{1'b0, dBus_cmd_payload_address[1:0], m_axi_bresp[0],
                           m_axi_rresp[0], (TIMEOUT_CYCLES < 2)};

`ifdef DBUS_BRIDGE_TIMEOUT_EN
    logic [31:0] tmo_count;

    // Counts cycles spent since the access left IDLE; RSP is never long enough to matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_count <= '0;
        end else if (state == IDLE) begin
            tmo_count <= '0;
        end else begin
            tmo_count <= tmo_count + 32'd1;
        end
    end

    assign tmo_hit = (tmo_count >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            dBus_rsp_valid         <= 1'b0;
            dBus_rsp_payload_data  <= '0;
            dBus_rsp_payload_error <= 1'b0;
            wr_error               <= 1'b0;
            m_axi_awaddr           <= '0;
            m_axi_awvalid          <= 1'b0;
            m_axi_wdata            <= '0;
            m_axi_wstrb            <= '0;
            m_axi_wvalid           <= 1'b0;
            m_axi_bready           <= 1'b0;
            m_axi_araddr           <= '0;
            m_axi_arvalid          <= 1'b0;
            m_axi_rready           <= 1'b0;
        end else begin
            dBus_rsp_valid <= 1'b0;
            wr_error       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (size_bad) begin
                            if (dBus_cmd_payload_wr) begin
                                wr_error <= 1'b1;
                            end else begin
                                dBus_rsp_valid         <= 1'b1;
                                dBus_rsp_payload_data  <= '0;
                                dBus_rsp_payload_error <= 1'b1;
                                state                  <= RSP;
                            end
                        end else if (dBus_cmd_payload_wr) begin
                            m_axi_awaddr  <= word_addr;
                            m_axi_wdata   <= dBus_cmd_payload_data;
                            m_axi_wstrb   <= dBus_cmd_payload_mask;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= word_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RA;
                        end
                    end
                end
                WR: begin
                    if (aw_done && w_done) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_bready  <= 1'b1;
                        state         <= WB;
                    end else if (tmo_hit) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        wr_error      <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        if (m_axi_awready) begin
                            m_axi_awvalid <= 1'b0;
                        end
                        if (m_axi_wready) begin
                            m_axi_wvalid <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        wr_error     <= m_axi_bresp[1];
                        state        <= IDLE;
                    end else if (tmo_hit) begin
                        m_axi_bready <= 1'b0;
                        wr_error     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RA: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD;
                    end else if (tmo_hit) begin
                        m_axi_arvalid          <= 1'b0;
                        dBus_rsp_valid         <= 1'b1;
                        dBus_rsp_payload_data  <= '0;
                        dBus_rsp_payload_error <= 1'b1;
                        state                  <= RSP;
                    end
                end
                RD: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready           <= 1'b0;
                        dBus_rsp_valid         <= 1'b1;
                        dBus_rsp_payload_data  <= m_axi_rdata;
                        dBus_rsp_payload_error <= m_axi_rresp[1];
                        state                  <= RSP;
                    end else if (tmo_hit) begin
                        m_axi_rready           <= 1'b0;
                        dBus_rsp_valid         <= 1'b1;
                        dBus_rsp_payload_data  <= '0;
                        dBus_rsp_payload_error <= 1'b1;
                        state                  <= RSP;
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_axil_bridge.sv
// Self-checking bench for dbus_axil_bridge: configurable AXI-Lite slave, queue-based expectation model.
// Timeout scenarios are exercised only when DBUS_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_dbus_axil_bridge;

    localparam int ADDR_W = 32;
    localparam int TMO    = 8;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dBus_cmd_valid = 1'b0;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr = 1'b0;
    logic [31:0] dBus_cmd_payload_address = '0;
    logic [31:0] dBus_cmd_payload_data = '0;
    logic [3:0]  dBus_cmd_payload_mask = '0;
    logic [2:0]  dBus_cmd_payload_size = '0;
    logic        dBus_rsp_valid;
    logic [31:0] dBus_rsp_payload_data;
    logic        dBus_rsp_payload_error;
    logic        wr_error;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    dbus_axil_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
        .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
        .dBus_cmd_payload_address(dBus_cmd_payload_address),
        .dBus_cmd_payload_data(dBus_cmd_payload_data),
        .dBus_cmd_payload_mask(dBus_cmd_payload_mask),
        .dBus_cmd_payload_size(dBus_cmd_payload_size),
        .dBus_rsp_valid(dBus_rsp_valid), .dBus_rsp_payload_data(dBus_rsp_payload_data),
        .dBus_rsp_payload_error(dBus_rsp_payload_error), .wr_error(wr_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // Slave behaviour knobs: wait cycles before each ready/valid and the response contents.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          r_never = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    always @(posedge clk) begin : slave
        #1;
        if (reset) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == aw_delay); aw_cnt++; end
            else begin m_axi_awready = 1'b0; aw_cnt = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_cnt == w_delay); w_cnt++; end
            else begin m_axi_wready = 1'b0; w_cnt = 0; end
            if (m_axi_bready) begin m_axi_bvalid = (b_cnt == b_delay); b_cnt++; end
            else begin m_axi_bvalid = 1'b0; b_cnt = 0; end
            if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == ar_delay); ar_cnt++; end
            else begin m_axi_arready = 1'b0; ar_cnt = 0; end
            if (m_axi_rready && !r_never) begin m_axi_rvalid = (r_cnt == r_delay); r_cnt++; end
            else begin m_axi_rvalid = 1'b0; r_cnt = 0; end
            m_axi_bresp = bresp_cfg;
            m_axi_rresp = rresp_cfg;
            m_axi_rdata = rdata_cfg;
        end
    end

    // Expectation model: edges are the clock edge that captures the visible value.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          edge_n;
    } rsp_t;

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_wd_q[$];
    logic [3:0]  exp_ws_q[$];
    logic [31:0] exp_ar_q[$];
    rsp_t        exp_rsp_q[$];
    int          exp_wrerr_q[$];

    task automatic model_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [2:0] size, input int n);
        logic [31:0] wa;
        int slow;
        int hs;
        wa = {addr[31:2], 2'b00};
        if (size > 3'd2) begin
            if (wr) exp_wrerr_q.push_back(n + 1);
            else exp_rsp_q.push_back('{data: 32'h0, err: 1'b1, edge_n: n + 1});
        end else if (wr) begin
            slow = (aw_delay > w_delay) ? aw_delay : w_delay;
            hs = n + 2 + slow + b_delay;
            exp_aw_q.push_back(wa);
            exp_wd_q.push_back(data);
            exp_ws_q.push_back(mask);
            if (bresp_cfg[1]) exp_wrerr_q.push_back(hs + 1);
        end else begin
            hs = n + 2 + ar_delay + r_delay;
            exp_ar_q.push_back(wa);
            if (TMO_EN && (r_never || hs > n + TMO))
                exp_rsp_q.push_back('{data: 32'h0, err: 1'b1, edge_n: n + TMO + 1});
            else
                exp_rsp_q.push_back('{data: rdata_cfg, err: rresp_cfg[1], edge_n: hs + 1});
        end
    endtask

    logic [31:0] last_rsp_data = '0;
    logic        last_rsp_err = 1'b0;
    int          last_rsp_edge = 0, last_wrerr_edge = 0;
    logic [31:0] last_awaddr = '0;
    logic [3:0]  last_wstrb = '0;
    int          aw_edge = 0, w_edge = 0, b_hs_count = 0, wrerr_count = 0;
    bit          aw_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] prev_awaddr = '0, prev_araddr = '0;

    always @(negedge clk) begin : compare
        int e;
        rsp_t r;
        e = cyc + 1;
        if (reset) begin
            aw_pend = 1'b0;
            ar_pend = 1'b0;
        end else begin
            checkOutput("axi_exclusive", 32'((m_axi_awvalid | m_axi_wvalid) & m_axi_arvalid), 32'd0);
            checkOutput("prot_zero", {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
            checkOutput("ready_exclusive", 32'(m_axi_bready & m_axi_rready), 32'd0);
            if (aw_pend) begin
                checkOutput("aw_stable_valid", 32'(m_axi_awvalid), 32'd1);
                checkOutput("aw_stable_addr", m_axi_awaddr, prev_awaddr);
            end
            if (ar_pend) begin
                checkOutput("ar_stable_valid", 32'(m_axi_arvalid), 32'd1);
                checkOutput("ar_stable_addr", m_axi_araddr, prev_araddr);
            end
            aw_pend = m_axi_awvalid && !m_axi_awready;
            ar_pend = m_axi_arvalid && !m_axi_arready;
            prev_awaddr = m_axi_awaddr;
            prev_araddr = m_axi_araddr;
            if (m_axi_awvalid) begin
                if (exp_aw_q.size() == 0) checkOutput("aw_unexpected", 32'd1, 32'd0);
                else if (m_axi_awready) begin
                    checkOutput("awaddr", m_axi_awaddr, exp_aw_q.pop_front());
                    last_awaddr = m_axi_awaddr;
                    aw_edge = e;
                end
            end
            if (m_axi_wvalid) begin
                if (exp_wd_q.size() == 0) checkOutput("w_unexpected", 32'd1, 32'd0);
                else if (m_axi_wready) begin
                    checkOutput("wdata", m_axi_wdata, exp_wd_q.pop_front());
                    checkOutput("wstrb", 32'(m_axi_wstrb), 32'(exp_ws_q.pop_front()));
                    last_wstrb = m_axi_wstrb;
                    w_edge = e;
                end
            end
            if (m_axi_arvalid) begin
                if (exp_ar_q.size() == 0) checkOutput("ar_unexpected", 32'd1, 32'd0);
                else if (m_axi_arready) checkOutput("araddr", m_axi_araddr, exp_ar_q.pop_front());
            end
            if (m_axi_bvalid && m_axi_bready) b_hs_count++;
            if (dBus_rsp_valid) begin
                if (exp_rsp_q.size() == 0) checkOutput("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    r = exp_rsp_q.pop_front();
                    checkOutput("rsp_data", dBus_rsp_payload_data, r.data);
                    checkOutput("rsp_error", 32'(dBus_rsp_payload_error), 32'(r.err));
                    checkOutput("rsp_edge", e, r.edge_n);
                    last_rsp_data = dBus_rsp_payload_data;
                    last_rsp_err = dBus_rsp_payload_error;
                    last_rsp_edge = e;
                end
            end else if (exp_rsp_q.size() > 0 && exp_rsp_q[0].edge_n <= e) begin
                checkOutput("rsp_missing", e, exp_rsp_q[0].edge_n);
                void'(exp_rsp_q.pop_front());
            end
            if (wr_error) begin
                wrerr_count++;
                last_wrerr_edge = e;
                if (exp_wrerr_q.size() == 0) checkOutput("wr_error_unexpected", 32'd1, 32'd0);
                else checkOutput("wr_error_edge", e, exp_wrerr_q.pop_front());
            end else if (exp_wrerr_q.size() > 0 && exp_wrerr_q[0] <= e) begin
                checkOutput("wr_error_missing", e, exp_wrerr_q[0]);
                void'(exp_wrerr_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, input logic [2:0] size, output int n);
        int guard;
        guard = 0;
        n = -1;
        @(negedge clk);
        while (!dBus_cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!dBus_cmd_ready) begin
            checkOutput("cmd_ready_wait", 32'd0, 32'd1);
            return;
        end
        dBus_cmd_payload_wr = wr;
        dBus_cmd_payload_address = addr;
        dBus_cmd_payload_data = data;
        dBus_cmd_payload_mask = mask;
        dBus_cmd_payload_size = size;
        dBus_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        dBus_cmd_valid = 1'b0;
        model_cmd(wr, addr, data, mask, size, n);
    endtask

    task automatic wait_idle(input int budget, output int edge_out);
        int k;
        k = 0;
        edge_out = -1;
        do begin
            @(negedge clk);
            k++;
        end while (!(dBus_cmd_ready && exp_rsp_q.size() == 0 && exp_wrerr_q.size() == 0 &&
                     exp_aw_q.size() == 0 && exp_wd_q.size() == 0 && exp_ar_q.size() == 0) &&
                   k < budget);
        if (k >= budget) checkOutput("idle_wait", 32'd0, 32'd1);
        else edge_out = cyc + 1;
    endtask

    task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd);
        aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stim
        int n;
        int done;
        int cnt0;

        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(dBus_cmd_ready), 32'd0);
        checkOutput("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                   m_axi_bready, m_axi_rready}, 32'd0);
        checkOutput("rst_rsp_valid", 32'(dBus_rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", dBus_rsp_payload_data, 32'd0);
        checkOutput("rst_rsp_error", 32'(dBus_rsp_payload_error), 32'd0);
        checkOutput("rst_wr_error", 32'(wr_error), 32'd0);
        reset = 1'b0;

        // Zero-wait read: response captured three edges after acceptance.
        set_slave(0, 0, 0, 0, 0);
        rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
        applyStimulus(1'b0, 32'h1000_0004, 32'h0, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t1_data", last_rsp_data, 32'hDEADBEEF);
        checkOutput("t1_error", 32'(last_rsp_err), 32'd0);
        checkOutput("t1_latency", last_rsp_edge - n, 32'd3);

        // Byte write with W accepted three cycles after AW.
        set_slave(0, 3, 0, 0, 0);
        bresp_cfg = 2'b00;
        cnt0 = b_hs_count;
        applyStimulus(1'b1, 32'h1000_0003, 32'hAB00_0000, 4'b1000, 3'd0, n);
        wait_idle(50, done);
        checkOutput("t2_awaddr", last_awaddr, 32'h1000_0000);
        checkOutput("t2_wstrb", 32'(last_wstrb), 32'h8);
        checkOutput("t2_w_gap", w_edge - aw_edge, 32'd3);
        checkOutput("t2_b_count", b_hs_count - cnt0, 32'd1);
        checkOutput("t2_ready_back", done - n, 32'd6);

        // Read answered with SLVERR after some wait states.
        set_slave(0, 0, 0, 2, 1);
        rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
        applyStimulus(1'b0, 32'h4000_0010, 32'h0, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t3_error", 32'(last_rsp_err), 32'd1);
        checkOutput("t3_latency", last_rsp_edge - n, 32'd6);

        // Write answered with DECERR: exactly one wr_error pulse.
        set_slave(2, 0, 2, 0, 0);
        bresp_cfg = 2'b11;
        cnt0 = wrerr_count;
        applyStimulus(1'b1, 32'h5000_0008, 32'h0102_0304, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t4_wr_error_pulses", wrerr_count - cnt0, 32'd1);
        checkOutput("t4_wr_error_edge", last_wrerr_edge - n, 32'd7);
        bresp_cfg = 2'b00;

        // Illegal size read: error response one edge after accept, no AR traffic.
        set_slave(0, 0, 0, 0, 0);
        applyStimulus(1'b0, 32'h1000_0000, 32'h0, 4'hF, 3'd3, n);
        wait_idle(50, done);
        checkOutput("t5_edge", last_rsp_edge - n, 32'd1);
        checkOutput("t5_error", 32'(last_rsp_err), 32'd1);
        checkOutput("t5_data", last_rsp_data, 32'd0);

        // Illegal size write: wr_error pulse one edge after accept, no AW traffic.
        cnt0 = wrerr_count;
        applyStimulus(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 3'd4, n);
        wait_idle(50, done);
        checkOutput("t6_pulses", wrerr_count - cnt0, 32'd1);
        checkOutput("t6_edge", last_wrerr_edge - n, 32'd1);

        // Halfword write with AW slower than W, then a delayed read.
        set_slave(3, 0, 1, 1, 4);
        rdata_cfg = 32'h0BAD_F00D; rresp_cfg = 2'b00;
        applyStimulus(1'b1, 32'h2000_0006, 32'hBEEF_0000, 4'b1100, 3'd1, n);
        wait_idle(50, done);
        checkOutput("t7_awaddr", last_awaddr, 32'h2000_0004);
        checkOutput("t7_ready_back", done - n, 32'd7);
        applyStimulus(1'b0, 32'h2000_0007, 32'h0, 4'hF, 3'd0, n);
        wait_idle(50, done);
        checkOutput("t7_read_data", last_rsp_data, 32'h0BAD_F00D);

        // Reset while waiting for R: everything back to reset values, no response.
        set_slave(0, 0, 0, 0, 30);
        rdata_cfg = 32'h7777_7777;
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3'd2, n);
        begin
            int k;
            k = 0;
            while (!m_axi_rready && k < 20) begin @(negedge clk); k++; end
            checkOutput("t8_reached_rd", 32'(m_axi_rready), 32'd1);
        end
        reset = 1'b1;
        #1;
        checkOutput("t8_rready", 32'(m_axi_rready), 32'd0);
        checkOutput("t8_cmd_ready", 32'(dBus_cmd_ready), 32'd0);
        checkOutput("t8_rsp_valid", 32'(dBus_rsp_valid), 32'd0);
        checkOutput("t8_rsp_data", dBus_rsp_payload_data, 32'd0);
        checkOutput("t8_arvalid", 32'(m_axi_arvalid), 32'd0);
        exp_rsp_q.delete(); exp_wrerr_q.delete(); exp_aw_q.delete();
        exp_wd_q.delete(); exp_ar_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        set_slave(0, 0, 0, 0, 0);
        rdata_cfg = 32'hCAFE_F00D;
        applyStimulus(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t8_after_data", last_rsp_data, 32'hCAFE_F00D);
        checkOutput("t8_after_latency", last_rsp_edge - n, 32'd3);

`ifdef DBUS_BRIDGE_TIMEOUT_EN
        // R never arrives: watchdog produces an error response.
        r_never = 1'b1;
        applyStimulus(1'b0, 32'h6000_0000, 32'h0, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t9_error", 32'(last_rsp_err), 32'd1);
        checkOutput("t9_data", last_rsp_data, 32'd0);
        checkOutput("t9_edge", last_rsp_edge - n, 32'd9);
        checkOutput("t9_rready", 32'(m_axi_rready), 32'd0);
        // R arrives in the same cycle as the timeout: normal data wins.
        r_never = 1'b0;
        set_slave(0, 0, 0, 0, 6);
        rdata_cfg = 32'h55AA_55AA;
        applyStimulus(1'b0, 32'h6000_0004, 32'h0, 4'hF, 3'd2, n);
        wait_idle(50, done);
        checkOutput("t10_data", last_rsp_data, 32'h55AA_55AA);
        checkOutput("t10_error", 32'(last_rsp_err), 32'd0);
        checkOutput("t10_edge", last_rsp_edge - n, 32'd9);
`endif

        repeat (3) @(negedge clk);
        checkOutput("queues_drained", exp_rsp_q.size() + exp_wrerr_q.size() + exp_aw_q.size() +
                                      exp_wd_q.size() + exp_ar_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
